// File: rtl/onehot_counter_monitor.sv
// Decoder and checker for a one-hot ring counter: registers the binary index, flags
// non-one-hot samples and out-of-sequence steps. Optional wrap flag: ONEHOT_MONITOR_WRAP_FLAG_EN.
module onehot_counter_monitor #(
   parameter int WIDTH    = 8,
   parameter int IDX_W    = $clog2(WIDTH),
   parameter int ERRCNT_W = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [WIDTH-1:0]    onehot_in,
   input  logic                enable_in,
   input  logic                clear_err,
   output logic [IDX_W-1:0]    index,
   output logic                index_valid,
   output logic                onehot_err,
   output logic                seq_err,
   output logic                locked,
   output logic                err_sticky,
   output logic [ERRCNT_W-1:0] err_count
`ifdef ONEHOT_MONITOR_WRAP_FLAG_EN
   ,
   output logic                wrap_pulse
`endif
);

   typedef enum logic [1:0] {ST_UNLOCKED, ST_LOCKED, ST_FAULT} state_t;

   state_t           state;
   logic [WIDTH-1:0] prev;
   logic             prev_en;
   logic [WIDTH-1:0] expected;
   logic [IDX_W-1:0] dec_idx;
   logic             valid;
   logic             seq_miss;
   logic             err_now;

   always_comb begin
      valid   = ($countones(onehot_in) == 1);
      dec_idx = '0;
      for (int i = 0; i < WIDTH; i++)
         if (onehot_in[i]) dec_idx = IDX_W'(i);
   end

   // The observed counter only moves on the cycle after its enable was high.
   always_comb begin
      expected = prev;
      if (prev_en) expected = prev[WIDTH-1] ? WIDTH'(1) : (prev << 1);
   end

   assign seq_miss = (state == ST_LOCKED) && valid && (onehot_in != expected);
   assign err_now  = !valid || seq_miss;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ST_UNLOCKED;
         prev        <= '0;
         prev_en     <= 1'b0;
         index       <= '0;
         index_valid <= 1'b0;
         onehot_err  <= 1'b0;
         seq_err     <= 1'b0;
         locked      <= 1'b0;
         err_sticky  <= 1'b0;
         err_count   <= '0;
`ifdef ONEHOT_MONITOR_WRAP_FLAG_EN
         wrap_pulse  <= 1'b0;
`endif
      end else begin
         index       <= valid ? dec_idx : '0;
         index_valid <= valid;
         onehot_err  <= !valid;
         prev_en     <= enable_in;
         seq_err     <= 1'b0;
`ifdef ONEHOT_MONITOR_WRAP_FLAG_EN
         wrap_pulse  <= 1'b0;
`endif
         if (clear_err) begin
            // Clear wins over any error detected this cycle.
            state      <= ST_UNLOCKED;
            locked     <= 1'b0;
            err_sticky <= 1'b0;
            err_count  <= '0;
         end else begin
            if (err_now) begin
               err_sticky <= 1'b1;
               if (err_count != '1) err_count <= err_count + ERRCNT_W'(1);
            end
            case (state)
               ST_UNLOCKED: if (valid) begin
                  state  <= ST_LOCKED;
                  locked <= 1'b1;
                  prev   <= onehot_in;
               end
               ST_LOCKED: begin
                  if (valid) prev <= onehot_in;
                  if (!valid || seq_miss) begin
                     state  <= ST_FAULT;
                     locked <= 1'b0;
                     seq_err <= seq_miss;
                  end
`ifdef ONEHOT_MONITOR_WRAP_FLAG_EN
                  else wrap_pulse <= prev_en && prev[WIDTH-1];
`endif
               end
               ST_FAULT: ;
               default: begin
                  state  <= ST_UNLOCKED;
                  locked <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_onehot_counter_monitor.sv
// Directed bench for onehot_counter_monitor (WIDTH=8), hand-computed expectations.
module tb_onehot_counter_monitor;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] onehot_in = '0;
   logic       enable_in = 1'b0;
   logic       clear_err = 1'b0;
   logic [2:0] index;
   logic       index_valid, onehot_err, seq_err, locked, err_sticky;
   logic [7:0] err_count;
`ifdef ONEHOT_MONITOR_WRAP_FLAG_EN
   logic       wrap_pulse;
`endif

   int n_chk  = 0;
   int n_fail = 0;
   int cur;
   logic [49:0] en_pat;

   onehot_counter_monitor #(.WIDTH(8), .ERRCNT_W(8)) dut (
      .clk(clk), .rst(rst), .onehot_in(onehot_in), .enable_in(enable_in),
      .clear_err(clear_err), .index(index), .index_valid(index_valid),
      .onehot_err(onehot_err), .seq_err(seq_err), .locked(locked),
      .err_sticky(err_sticky), .err_count(err_count)
`ifdef ONEHOT_MONITOR_WRAP_FLAG_EN
      , .wrap_pulse(wrap_pulse)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [7:0] v, input logic en, input logic clr);
      onehot_in = v;
      enable_in = en;
      clear_err = clr;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_idx"}, index, 0);
      chk({tag, "_vld"}, index_valid, 0);
      chk({tag, "_oherr"}, onehot_err, 0);
      chk({tag, "_seqerr"}, seq_err, 0);
      chk({tag, "_lock"}, locked, 0);
      chk({tag, "_sticky"}, err_sticky, 0);
      chk({tag, "_cnt"}, err_count, 0);
`ifdef ONEHOT_MONITOR_WRAP_FLAG_EN
      chk({tag, "_wrap"}, wrap_pulse, 0);
`endif
   endtask

   initial begin
      // reset state
      tick(); tick();
      chk_all_zero("reset");
      rst = 1'b0;

      // free-running count, enable always high
      for (int i = 0; i < 20; i++) begin
         drive(8'b1 << (i % 8), 1'b1, 1'b0);
         tick();
         chk("run_idx", index, i % 8);
         chk("run_lock", locked, 1);
         chk("run_seqerr", seq_err, 0);
         chk("run_oherr", onehot_err, 0);
`ifdef ONEHOT_MONITOR_WRAP_FLAG_EN
         chk("run_wrap", wrap_pulse, (i > 0 && i % 8 == 0) ? 1 : 0);
`endif
      end
      chk("run_cnt", err_count, 0);
      cur = 4;

      // enable toggling: index holds when the previous enable was low
      en_pat = 50'h2D5B39A6CE1F4;
      for (int i = 0; i < 50; i++) begin
         drive(8'b1 << cur, en_pat[i], 1'b0);
         tick();
         chk("tog_idx", index, cur);
         chk("tog_seqerr", seq_err, 0);
         chk("tog_lock", locked, 1);
         if (en_pat[i]) cur = (cur + 1) % 8;
      end

      // step to index 3, then inject two set bits
      for (int i = 0; i < 8 && cur != 3; i++) begin
         drive(8'b1 << cur, 1'b1, 1'b0);
         tick();
         cur = (cur + 1) % 8;
      end
      drive(8'h08, 1'b0, 1'b0);
      tick();
      chk("at3_idx", index, 3);
      chk("at3_lock", locked, 1);
      drive(8'b0001_0100, 1'b0, 1'b0);
      tick();
      chk("multi_oherr", onehot_err, 1);
      chk("multi_vld", index_valid, 0);
      chk("multi_idx", index, 0);
      chk("multi_cnt", err_count, 1);
      chk("multi_sticky", err_sticky, 1);
      chk("multi_lock", locked, 0);
      drive(8'h01, 1'b1, 1'b0);
      tick();
      chk("fault_idx", index, 0);
      chk("fault_vld", index_valid, 1);
      chk("fault_lock", locked, 0);
      chk("fault_cnt", err_count, 1);

      // clear, relock at 0x04, then an out-of-sequence jump
      drive(8'h04, 1'b0, 1'b1);
      tick();
      chk("clr_cnt", err_count, 0);
      chk("clr_sticky", err_sticky, 0);
      chk("clr_idx", index, 2);
      drive(8'h04, 1'b1, 1'b0);
      tick();
      chk("relock", locked, 1);
      drive(8'h10, 1'b0, 1'b0);
      tick();
      chk("jump_seqerr", seq_err, 1);
      chk("jump_oherr", onehot_err, 0);
      chk("jump_idx", index, 4);
      chk("jump_cnt", err_count, 1);
      chk("jump_lock", locked, 0);
      drive(8'h20, 1'b0, 1'b0);
      tick();
      chk("fault_noseq", seq_err, 0);
      drive(8'h20, 1'b0, 1'b1);
      tick();
      chk("clr2_cnt", err_count, 0);
      chk("clr2_sticky", err_sticky, 0);
      drive(8'h20, 1'b0, 1'b0);
      tick();
      chk("relock2", locked, 1);

      // counter saturation with a dead input
      for (int i = 1; i <= 300; i++) begin
         drive(8'h00, 1'b0, 1'b0);
         tick();
         if (i == 1) chk("zero_cnt1", err_count, 1);
         if (i == 255) chk("zero_cnt255", err_count, 255);
      end
      chk("sat_cnt", err_count, 255);
      chk("sat_oherr", onehot_err, 1);
      chk("sat_sticky", err_sticky, 1);
      drive(8'h00, 1'b0, 1'b1);
      tick();
      chk("clrerr_cnt", err_count, 0);
      chk("clrerr_sticky", err_sticky, 0);
      chk("clrerr_oherr", onehot_err, 1);
      drive(8'h00, 1'b0, 1'b0);
      tick();
      chk("after_clr_cnt", err_count, 1);

      // relock from 0x01, run to index 5, reset mid-sequence
      cur = 0;
      for (int i = 0; i < 8 && !(cur == 5 && i > 0); i++) begin
         drive(8'b1 << cur, 1'b1, 1'b0);
         tick();
         chk("pre_idx", index, cur);
         cur = (cur + 1) % 8;
      end
      chk("pre_lock", locked, 1);
      drive(8'h20, 1'b1, 1'b0);
      tick();
      chk("at5_idx", index, 5);
      rst = 1'b1;
      #2;
      chk_all_zero("midrst");
      tick();
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         drive(8'b1 << (i % 8), 1'b1, 1'b0);
         tick();
         chk("post_idx", index, i % 8);
         chk("post_lock", locked, 1);
         chk("post_seqerr", seq_err, 0);
      end
      chk("post_cnt", err_count, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/onehot_counter_monitor.md
Name: onehot_counter_monitor

Overview:
- Receive-side decoder and checker for a one-hot ring counter output (LSB-reset, shift-left, wrap MSB->LSB on enable).
- Registers the sampled vector and converts it to a binary index.
- Validates one-hot encoding and checks that the sequence advances exactly as the counter's enable dictates.
- Sits beside or downstream of any one-hot counter; used for index recovery and safety/fault monitoring.

Parameters:
- WIDTH, 8, one-hot vector width; legal range 2..64.
- IDX_W, $clog2(WIDTH), binary index width; derived, do not override.
- ERRCNT_W, 8, width of the saturating error counter.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- onehot_in  input  WIDTH  one-hot count vector under observation.
- enable_in  input  1  same enable that drives the observed counter. High in cycle t means onehot_in must advance in cycle t+1.
- clear_err  input  1  synchronous pulse; clears sticky error and error counter and returns the FSM to UNLOCKED.
- index  output  IDX_W  registered binary position of the set bit.
- index_valid  output  1  registered; onehot_in had exactly one bit set.
- onehot_err  output  1  one-cycle pulse; onehot_in had zero bits set or more than one bit set.
- seq_err  output  1  one-cycle pulse; valid one-hot input differed from the expected value while LOCKED.
- locked  output  1  FSM is in LOCKED.
- err_sticky  output  1  set on any error; held until clear_err or reset.
- err_count  output  ERRCNT_W  count of error cycles; saturates at all-ones.

Behaviour:
- Reset (async, rst=1):
  - index=0, index_valid=0, onehot_err=0, seq_err=0, locked=0, err_sticky=0, err_count=0.
  - FSM=UNLOCKED; internal prev vector=0; internal prev_en=0.
- Latency: all outputs are registered. Outputs in cycle t+1 reflect onehot_in and enable_in sampled at edge t.
- Decode:
  - valid = popcount(onehot_in)==1.
  - index = position of the set bit when valid, else 0.
  - onehot_err = !valid, in every FSM state.
- Expected value, computed from prev (last valid vector) and prev_en (enable_in of the previous cycle):
  - prev_en=0 -> expected = prev.
  - prev_en=1 and prev[WIDTH-1]=1 -> expected = 1 (wrap to LSB).
  - prev_en=1 otherwise -> expected = prev<<1.
- FSM states: UNLOCKED, LOCKED, FAULT.
  - UNLOCKED: valid input -> LOCKED; prev<=onehot_in. Invalid input -> stay UNLOCKED, onehot_err pulses. No seq checking in this state.
  - LOCKED, valid and equal to expected -> stay; prev<=onehot_in.
  - LOCKED, valid and not equal to expected -> seq_err pulse; FAULT; prev<=onehot_in.
  - LOCKED, invalid input -> onehot_err pulse; FAULT; prev unchanged.
  - FAULT: index/index_valid keep tracking the input. onehot_err still reported; seq_err not reported. Exit only via clear_err -> UNLOCKED.
- prev_en <= enable_in every cycle, in all states.
- Error bookkeeping:
  - Any cycle with onehot_err or seq_err asserted sets err_sticky and increments err_count by exactly 1, even when both are asserted.
  - err_count saturates; no wrap.
- clear_err:
  - Takes priority over the same-cycle error increment: err_count<=0, err_sticky<=0, FSM<=UNLOCKED.
  - The decode outputs for that cycle still update normally.
- locked = (FSM==LOCKED), registered with the state.
- Reset asserted mid-operation: immediate return to the reset values above. After release, the first valid sample relocks.

Optional Feature:
- Macro: ONEHOT_MONITOR_WRAP_FLAG_EN.
- When defined:
  - Extra output port wrap_pulse (1 bit), reset 0.
  - wrap_pulse pulses for one cycle, aligned with index, when LOCKED and a valid input equals expected==1 with prev[WIDTH-1]=1 and prev_en=1, i.e. a legal MSB->LSB wrap.
- When undefined: port and logic are absent; all other behaviour is identical.

Test Plan (WIDTH=8):
- Reset, then drive a reference counter with enable=1 for 20 cycles -> locked=1 one cycle after the first sample. index steps 0..7,0..; no errors; err_count=0. With the macro defined, wrap_pulse=1 on each 7->0.
- Enable toggled pseudo-randomly for 50 cycles -> index holds whenever enable was low the previous cycle; seq_err never asserts.
- While LOCKED with index=3, force onehot_in=8'b0001_0100 -> next cycle onehot_err=1, index_valid=0, err_count=1, err_sticky=1. FSM enters FAULT; locked=0.
- While LOCKED at 8'h04, enable=1, inject 8'h10 -> seq_err=1, err_count=1, FAULT. Pulse clear_err -> err_count=0, err_sticky=0; relocked the cycle after the next valid sample.
- Hold onehot_in=0 for 300 cycles with ERRCNT_W=8 -> err_count saturates at 255. Assert clear_err in the same cycle as an error -> err_count=0.
- Assert rst mid-sequence at index=5 -> all outputs read 0 immediately. After release, the counter restarts at 8'h01, locks, and no seq_err is raised.
